adder_seq_ctrl: RTL

Sequencing controller that performs a wide add (4*NIBBLES bits) by reusing one 4-bit add slice (ina + inb + carry_in -> sum_out, carry_out) over multiple clock cycles.
- Each cycle it feeds one nibble pair and the registered carry to the slice.
- Each cycle it collects the result nibble and stores the carry for the next nibble.
- Sits between a requesting datapath (valid/ready input side) and a consumer (valid/ready output side).
- Provides a low-area wide adder built around the team's existing 4-bit full adder.

---
 rtl/adder_seq_ctrl_if.sv | 26 ++
 rtl/adder_seq_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl_if.sv
// Request/response bundle for the nibble-serial wide adder.
interface adder_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NIBBLES-1:0]   a_in;
  logic [4*NIBBLES-1:0]   b_in;
  logic                   c_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NIBBLES-1:0]   sum_out;
  logic                   c_out;
  logic                   overflow;
  logic                   busy;

  modport master (
    output in_valid, a_in, b_in, c_in, out_ready,
    input  in_ready, out_valid, sum_out, c_out, overflow, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, c_in, out_ready,
    output in_ready, out_valid, sum_out, c_out, overflow, busy
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Wide adder built from one 4-bit slice, one nibble per cycle; result valid NIBBLES
// edges after accept, held in DONE under out_ready back-pressure, new requests only in IDLE.
module add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = a + b + {3'b000, ci};
endmodule

module adder_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic             clk,
  input logic             rst,
  adder_seq_ctrl_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q, b_q, res_q, res_nxt, sum_q;
  logic          carry_q, c_out_q, ovf_q;
  logic [3:0]    a_nib, b_nib, slice_sum;
  logic          slice_co;
  logic          last;

  assign a_nib = a_q[4*idx +: 4];
  assign b_nib = b_q[4*idx +: 4];
  assign last  = (idx == IW'(NIBBLES - 1));

  add4 u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry_q),
    .s  (slice_sum),
    .co (slice_co)
  );

  always_comb begin
    res_nxt              = res_q;
    res_nxt[4*idx +: 4]  = slice_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output registers are separate from the working result so a new add never disturbs them mid-flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            carry_q <= bus.c_in;
            idx     <= '0;
            res_q   <= '0;
          end
        end
        RUN: begin
          res_q   <= res_nxt;
          carry_q <= slice_co;
          if (last) begin
            sum_q   <= res_nxt;
            c_out_q <= slice_co;
            ovf_q   <= (a_q[W-1] == b_q[W-1]) && (res_nxt[W-1] != a_q[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum_out   = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.overflow  = ovf_q;
endmodule
